simt_core: RTL and testbench

Parametrised multi-cycle GPU lane core: fetches one 32-bit instruction per pass, decodes, reads the register and predicate files, optionally performs one handshaked memory access, then executes and writes back. It sits between the scheduler (PC hand-out, work queue) and the per-lane register file, predicate file and data memory. It extends the 16-bit fixed core with:
- configurable data and PC widths;
- a valid/ack memory handshake with wait states;
- predicate negation, branch and halt;
- a synchronous reset.

---
 rtl/simt_core.sv | 171 +++++++++++++++++
 tb/tb_simt_core.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simt_core.sv
// Multi-cycle predicated GPU lane core: fetch/decode, operand and predicate read,
// optional handshaked memory access, then a single execute/write-back cycle.
module simt_core #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 16,
  parameter int QUEUE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    pc,
  input  logic [31:0]        instr,
  input  logic               hold,
  output logic               request_new_pc,
  input  logic               new_pc_valid,
  input  logic [PC_W-1:0]    new_pc,
  output logic [3:0]         readreg0,
  output logic [3:0]         readreg1,
  input  logic [DATA_W-1:0]  in_reg0,
  input  logic [DATA_W-1:0]  in_reg1,
  output logic               reg_wen,
  output logic [3:0]         reg_waddr,
  output logic [DATA_W-1:0]  reg_wval,
  output logic [1:0]         pred_raddr,
  input  logic               pred_val,
  output logic               pred_wen,
  output logic [1:0]         pred_waddr,
  output logic               pred_wval,
  output logic               mem_req,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               queue_wen,
  output logic [QUEUE_W-1:0] queue_number,
  output logic               halted
);

  localparam logic [4:0] OP_LD    = 5'd0;
  localparam logic [4:0] OP_ST    = 5'd1;
  localparam logic [4:0] OP_MUL   = 5'd2;
  localparam logic [4:0] OP_ADD   = 5'd3;
  localparam logic [4:0] OP_SUB   = 5'd4;
  localparam logic [4:0] OP_SHR   = 5'd5;
  localparam logic [4:0] OP_SHL   = 5'd6;
  localparam logic [4:0] OP_AND   = 5'd7;
  localparam logic [4:0] OP_NOT   = 5'd8;
  localparam logic [4:0] OP_XOR   = 5'd9;
  localparam logic [4:0] OP_OR    = 5'd10;
  localparam logic [4:0] OP_NAND  = 5'd11;
  localparam logic [4:0] OP_LDI   = 5'd12;
  localparam logic [4:0] OP_SETP  = 5'd13;
  localparam logic [4:0] OP_QPR   = 5'd14;
  localparam logic [4:0] OP_QPI   = 5'd15;
  localparam logic [4:0] OP_YIELD = 5'd16;
  localparam logic [4:0] OP_BRA   = 5'd17;
  localparam logic [4:0] OP_HALT  = 5'd18;

  typedef enum logic [2:0] {S_IDLE, S_DEC, S_REG, S_MEM, S_EXEC, S_HALT} state_t;

  state_t            state;
  logic [1:0]        pidx;
  logic              pneg;
  logic [4:0]        op;
  logic [3:0]        ra, rb, rd;
  logic [15:0]       imm;
  logic [DATA_W-1:0] va, vb, ldata;
  logic              ok;
  logic              ok_now, exec_ok;
  logic [DATA_W-1:0] imm_d;

  assign ok_now  = (pidx == 2'd0) | (pred_val ^ pneg);
  assign imm_d   = DATA_W'(imm);
  assign exec_ok = (state == S_EXEC) && ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      pidx  <= '0;
      pneg  <= 1'b0;
      op    <= '0;
      ra    <= '0;
      rb    <= '0;
      rd    <= '0;
      imm   <= '0;
      va    <= '0;
      vb    <= '0;
      ldata <= '0;
      ok    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (new_pc_valid) begin
          pc    <= new_pc;
          state <= S_DEC;
        end
        S_DEC: if (!hold) begin
          pidx  <= instr[31:30];
          pneg  <= instr[29];
          op    <= instr[28:24];
          ra    <= instr[23:20];
          rb    <= instr[19:16];
          rd    <= instr[15:12];
          imm   <= instr[15:0];
          state <= S_REG;
        end
        S_REG: begin
          va    <= in_reg0;
          vb    <= in_reg1;
          ok    <= ok_now;
          // predicated-off memory ops skip the handshake entirely
          state <= (ok_now && (op == OP_LD || op == OP_ST)) ? S_MEM : S_EXEC;
        end
        S_MEM: if (mem_ack) begin
          if (op == OP_LD) ldata <= mem_rdata;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (ok && op == OP_YIELD)     state <= S_IDLE;
          else if (ok && op == OP_HALT) state <= S_HALT;
          else begin
            pc    <= (ok && op == OP_BRA) ? PC_W'(imm) : pc + 1'b1;
            state <= S_DEC;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign request_new_pc = (state == S_IDLE);
  assign halted         = (state == S_HALT);
  assign readreg0       = ra;
  assign readreg1       = rb;
  assign pred_raddr     = pidx;

  // request fields come from latched operands, so they hold steady across wait states
  assign mem_req   = (state == S_MEM);
  assign mem_we    = mem_req && (op == OP_ST);
  assign mem_addr  = (op == OP_ST) ? vb : va;
  assign mem_wdata = va;

  assign reg_wen    = exec_ok && (op == OP_LD || (op >= OP_MUL && op <= OP_LDI));
  assign reg_waddr  = rd;
  assign pred_wen   = exec_ok && (op == OP_SETP);
  assign pred_waddr = rd[1:0];
  assign pred_wval  = (va < vb);
  assign queue_wen  = exec_ok && (op == OP_QPR || op == OP_QPI);
  assign queue_number = (op == OP_QPI) ? QUEUE_W'(imm) : QUEUE_W'(va);

  always_comb begin
    reg_wval = '0;
    case (op)
      OP_LD:   reg_wval = ldata;
      OP_MUL:  reg_wval = va * vb;
      OP_ADD:  reg_wval = va + vb;
      OP_SUB:  reg_wval = va - vb;
      OP_SHR:  reg_wval = va >> vb;
      OP_SHL:  reg_wval = va << vb;
      OP_AND:  reg_wval = va & vb;
      OP_NOT:  reg_wval = ~va;
      OP_XOR:  reg_wval = va ^ vb;
      OP_OR:   reg_wval = va | vb;
      OP_NAND: reg_wval = ~(va & vb);
      OP_LDI:  reg_wval = imm_d;
      default: reg_wval = '0;
    endcase
  end

endmodule

// File: tb/tb_simt_core.sv
// Bench for simt_core: table vectors, hand-written corner sequences and random
// instructions checked against an instruction-level reference model.
module tb_simt_core;
  localparam int DW = 16, PW = 16, QW = 4;

  logic clk = 0, rst = 1;
  logic [PW-1:0] pc, new_pc;
  logic [31:0] instr;
  logic hold, request_new_pc, new_pc_valid;
  logic [3:0] readreg0, readreg1, reg_waddr;
  logic [DW-1:0] in_reg0, in_reg1, reg_wval, mem_addr, mem_wdata, mem_rdata;
  logic reg_wen, pred_val, pred_wen, pred_wval, mem_req, mem_we, mem_ack, queue_wen, halted;
  logic [1:0] pred_raddr, pred_waddr;
  logic [QW-1:0] queue_number;

  simt_core #(.DATA_W(DW), .PC_W(PW), .QUEUE_W(QW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .hold(hold),
    .request_new_pc(request_new_pc), .new_pc_valid(new_pc_valid), .new_pc(new_pc),
    .readreg0(readreg0), .readreg1(readreg1), .in_reg0(in_reg0), .in_reg1(in_reg1),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wval(reg_wval),
    .pred_raddr(pred_raddr), .pred_val(pred_val),
    .pred_wen(pred_wen), .pred_waddr(pred_waddr), .pred_wval(pred_wval),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .queue_wen(queue_wen), .queue_number(queue_number), .halted(halted));

  always #5 clk = ~clk;

  // environment: register file, predicates, data memory, instruction word
  logic [DW-1:0] rf [16];
  logic [3:0]    pf;
  logic [DW-1:0] dmem [256];
  logic [31:0]   cur_instr = '0;
  logic [15:0]   bpc = '0;
  int  mem_delay = 1;
  int  mcnt = 0;
  bit  stray_ack = 0;
  int  checks = 0, errors = 0;

  assign instr     = cur_instr;
  assign in_reg0   = rf[readreg0];
  assign in_reg1   = rf[readreg1];
  assign pred_val  = pf[pred_raddr];
  assign mem_rdata = dmem[mem_addr[7:0]];
  assign mem_ack   = stray_ack | (mem_req && (mcnt == mem_delay - 1));

  always @(posedge clk) begin
    if (!mem_req || mem_ack) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end

  typedef struct {
    bit ok, mem, rw, pw, qw, st;
    logic [3:0] waddr; logic [15:0] wval;
    logic [1:0] paddr; logic pval; logic [3:0] qnum;
    logic [15:0] maddr, mwdata, npc;
    int mode;  // 0 continue, 1 idle, 2 halt
  } exp_t;

  typedef struct {
    int rw_n, rw_c, pw_n, pw_c, qw_n, qw_c, mreq_n;
    logic [3:0] waddr; logic [15:0] wval;
    logic [1:0] paddr; logic pval; logic [3:0] qnum;
    bit unstable; logic mwe; logic [15:0] maddr, mwdata, pc;
    logic reqpc, halted;
  } obs_t;

  typedef struct { string name; logic [4:0] op; logic [15:0] a, b, imm, wv; } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [1:0] pi, input logic pn, input logic [4:0] op,
                                      input logic [3:0] a, input logic [3:0] b, input logic [15:0] im);
    return {pi, pn, op, a, b, im};
  endfunction

  // ISA-level model: what one instruction should do to the machine state
  function automatic exp_t model(input logic [31:0] ins, input logic [15:0] cpc);
    exp_t e; logic [4:0] op; logic [15:0] a, b, imm; logic [31:0] prod;
    e = '{default: 0};
    op = ins[28:24]; a = rf[ins[23:20]]; b = rf[ins[19:16]]; imm = ins[15:0];
    e.ok = (ins[31:30] == 2'd0) || (pf[ins[31:30]] != ins[29]);
    e.npc = cpc + 16'd1; e.waddr = ins[15:12];
    if (e.ok) case (op)
      0:  begin e.mem = 1; e.rw = 1; e.maddr = a; e.wval = dmem[a[7:0]]; end
      1:  begin e.mem = 1; e.st = 1; e.maddr = b; e.mwdata = a; end
      2:  begin prod = a * b; e.rw = 1; e.wval = prod[15:0]; end
      3:  begin e.rw = 1; e.wval = a + b; end
      4:  begin e.rw = 1; e.wval = a - b; end
      5:  begin e.rw = 1; e.wval = (b >= 16) ? 16'd0 : a >> b; end
      6:  begin e.rw = 1; e.wval = (b >= 16) ? 16'd0 : a << b; end
      7:  begin e.rw = 1; e.wval = a & b; end
      8:  begin e.rw = 1; e.wval = ~a; end
      9:  begin e.rw = 1; e.wval = a ^ b; end
      10: begin e.rw = 1; e.wval = a | b; end
      11: begin e.rw = 1; e.wval = ~(a & b); end
      12: begin e.rw = 1; e.wval = imm; end
      13: begin e.pw = 1; e.paddr = ins[13:12]; e.pval = (a < b); end
      14: begin e.qw = 1; e.qnum = a[3:0]; end
      15: begin e.qw = 1; e.qnum = imm[3:0]; end
      16: begin e.mode = 1; e.npc = cpc; end
      17: e.npc = imm;
      18: begin e.mode = 2; e.npc = cpc; end
      default: ;
    endcase
    return e;
  endfunction

  // Called at a negedge with the core in DEC; returns at the negedge after EXEC.
  task automatic do_pass(input string tag, input logic [31:0] ins, input int delay,
                         input int hcyc, input bit stray, output int mode);
    exp_t e; obs_t o; int lat;
    e = model(ins, bpc);
    lat = hcyc + 3 + (e.mem ? delay : 0);
    cur_instr = ins; mem_delay = delay; stray_ack = stray && !e.mem;
    o = '{default: 0};
    for (int c = 1; c <= lat; c++) begin
      hold = (c <= hcyc);
      if (reg_wen) begin
        o.rw_n++; o.rw_c = c; o.waddr = reg_waddr; o.wval = reg_wval; rf[reg_waddr] = reg_wval;
      end
      if (pred_wen) begin
        o.pw_n++; o.pw_c = c; o.paddr = pred_waddr; o.pval = pred_wval; pf[pred_waddr] = pred_wval;
      end
      if (queue_wen) begin o.qw_n++; o.qw_c = c; o.qnum = queue_number; end
      if (mem_req) begin
        if (o.mreq_n == 0) begin o.mwe = mem_we; o.maddr = mem_addr; o.mwdata = mem_wdata; end
        else if (mem_we !== o.mwe || mem_addr !== o.maddr || mem_wdata !== o.mwdata) o.unstable = 1;
        o.mreq_n++;
        if (mem_ack && mem_we) dmem[mem_addr[7:0]] = mem_wdata;
      end
      @(negedge clk);
    end
    hold = 0; stray_ack = 0;
    o.pc = pc; o.reqpc = request_new_pc; o.halted = halted;
    chk({tag, ".reg_wen_count"}, o.rw_n, e.rw);
    if (e.rw) begin
      chk({tag, ".reg_wen_cycle"}, o.rw_c, lat);
      chk({tag, ".reg_waddr"}, o.waddr, e.waddr);
      chk({tag, ".reg_wval"}, o.wval, e.wval);
    end
    chk({tag, ".pred_wen_count"}, o.pw_n, e.pw);
    if (e.pw) begin
      chk({tag, ".pred_wen_cycle"}, o.pw_c, lat);
      chk({tag, ".pred_waddr"}, o.paddr, e.paddr);
      chk({tag, ".pred_wval"}, o.pval, e.pval);
    end
    chk({tag, ".queue_wen_count"}, o.qw_n, e.qw);
    if (e.qw) begin
      chk({tag, ".queue_wen_cycle"}, o.qw_c, lat);
      chk({tag, ".queue_number"}, o.qnum, e.qnum);
    end
    chk({tag, ".mem_req_cycles"}, o.mreq_n, e.mem ? delay : 0);
    if (e.mem) begin
      chk({tag, ".mem_unstable"}, o.unstable, 0);
      chk({tag, ".mem_we"}, o.mwe, e.st);
      chk({tag, ".mem_addr"}, o.maddr, e.maddr);
      if (e.st) chk({tag, ".mem_wdata"}, o.mwdata, e.mwdata);
    end
    chk({tag, ".pc"}, o.pc, e.npc);
    chk({tag, ".request_new_pc"}, o.reqpc, e.mode == 1);
    chk({tag, ".halted"}, o.halted, e.mode == 2);
    bpc = e.npc;
    mode = e.mode;
  endtask

  task automatic give_pc(input logic [15:0] v);
    chk("idle.request_new_pc", request_new_pc, 1);
    new_pc_valid = 1; new_pc = v;
    @(negedge clk);
    new_pc_valid = 0;
    chk("idle.pc_load", pc, v);
    bpc = v;
  endtask

  initial begin
    vec_t vt [14];
    int mode; bit found;
    logic [31:0] ins; logic [4:0] op;

    hold = 0; new_pc_valid = 0; new_pc = '0;
    pf = '0;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    for (int i = 0; i < 256; i++) dmem[i] = 16'($urandom);

    // rd occupies imm[15:12], so imm 0x3000 targets r3
    vt = '{
      '{"add_wrap", 5'd3,  16'hFFFF, 16'h0002, 16'h3000, 16'h0001},
      '{"sub_wrap", 5'd4,  16'h0001, 16'h0002, 16'h3000, 16'hFFFF},
      '{"mul_ovf",  5'd2,  16'h0100, 16'h0100, 16'h3000, 16'h0000},
      '{"mul",      5'd2,  16'h0003, 16'h0005, 16'h3000, 16'h000F},
      '{"shl_16",   5'd6,  16'h0001, 16'h0010, 16'h3000, 16'h0000},
      '{"shl_15",   5'd6,  16'h0001, 16'h000F, 16'h3000, 16'h8000},
      '{"shr_15",   5'd5,  16'h8000, 16'h000F, 16'h3000, 16'h0001},
      '{"shr_big",  5'd5,  16'h8000, 16'h0020, 16'h3000, 16'h0000},
      '{"and",      5'd7,  16'hF0F0, 16'hFF00, 16'h3000, 16'hF000},
      '{"not",      5'd8,  16'hF0F0, 16'hFF00, 16'h3000, 16'h0F0F},
      '{"xor",      5'd9,  16'hF0F0, 16'hFF00, 16'h3000, 16'h0FF0},
      '{"or",       5'd10, 16'hF0F0, 16'hFF00, 16'h3000, 16'hFFF0},
      '{"nand",     5'd11, 16'hF0F0, 16'hFF00, 16'h3000, 16'h0FFF},
      '{"ldi",      5'd12, 16'h1111, 16'h2222, 16'h30AB, 16'h30AB}
    };

    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset.pc", pc, 0);
    chk("reset.request_new_pc", request_new_pc, 1);
    chk("reset.reg_wen", reg_wen, 0);
    chk("reset.pred_wen", pred_wen, 0);
    chk("reset.queue_wen", queue_wen, 0);
    chk("reset.mem_req", mem_req, 0);
    chk("reset.halted", halted, 0);
    chk("reset.readreg0", readreg0, 0);

    // first instruction: LDI r3 at 0x0010
    give_pc(16'h0010);
    rf[3] = 16'h0000;
    do_pass("ldi_first", enc(0, 0, 12, 0, 0, 16'h30AB), 1, 0, 0, mode);
    chk("ldi_first.r3", rf[3], 16'h30AB);

    foreach (vt[i]) begin
      rf[1] = vt[i].a; rf[2] = vt[i].b; rf[3] = ~vt[i].wv;
      do_pass(vt[i].name, enc(0, 0, vt[i].op, 1, 2, vt[i].imm), 1, 0, 0, mode);
      chk({vt[i].name, ".table"}, rf[3], vt[i].wv);
    end

    // load with three MEM cycles: six-cycle pass
    rf[1] = 16'h0020; dmem[8'h20] = 16'hBEEF; rf[4] = 16'h0000;
    do_pass("ld_wait3", enc(0, 0, 0, 1, 0, 16'h4000), 3, 0, 0, mode);
    chk("ld_wait3.r4", rf[4], 16'hBEEF);

    rf[5] = 16'h1234; rf[6] = 16'h0030; dmem[8'h30] = 16'h0000;
    do_pass("st_wait2", enc(0, 0, 1, 5, 6, 16'h0000), 2, 0, 0, mode);
    chk("st_wait2.mem", dmem[8'h30], 16'h1234);

    // SETP p2, then a pneg-guarded instruction on p2 is suppressed
    rf[1] = 16'h0003; rf[2] = 16'h0005;
    do_pass("setp", enc(0, 0, 13, 1, 2, 16'h2000), 1, 0, 0, mode);
    chk("setp.p2", pf[2], 1);
    rf[7] = 16'h0000;
    do_pass("pred_off_ldi", enc(2, 1, 12, 0, 0, 16'h7777), 1, 0, 0, mode);
    chk("pred_off_ldi.r7", rf[7], 16'h0000);
    do_pass("pred_off_ld", enc(2, 1, 0, 1, 0, 16'h7000), 2, 0, 0, mode);
    do_pass("pred_on_ldi", enc(2, 0, 12, 0, 0, 16'h7777), 1, 0, 0, mode);
    chk("pred_on_ldi.r7", rf[7], 16'h7777);

    do_pass("hold2", enc(0, 0, 3, 1, 2, 16'h3000), 1, 2, 0, mode);
    do_pass("stray_ack", enc(0, 0, 9, 1, 2, 16'h3000), 1, 0, 1, mode);
    do_pass("bra", enc(0, 0, 17, 0, 0, 16'h0040), 1, 0, 0, mode);

    // pc wrap: yield, restart at 0xFFFF, run a NOP
    do_pass("yield", enc(0, 0, 16, 0, 0, 16'h0000), 1, 0, 0, mode);
    give_pc(16'hFFFF);
    do_pass("nop_wrap", enc(0, 0, 19, 0, 0, 16'h0000), 1, 0, 0, mode);

    for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
    pf = 4'($urandom);
    for (int n = 0; n < 200; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd18) op = 5'd19;
      ins = {2'($urandom_range(0, 3)), 1'($urandom), op, 4'($urandom), 4'($urandom), 16'($urandom)};
      if ($urandom_range(0, 1) == 1) rf[ins[19:16]] = 16'($urandom_range(0, 20));
      do_pass("rand", ins, $urandom_range(1, 4), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
              1'($urandom), mode);
      if (mode == 1) give_pc(16'($urandom));
    end

    // reset while a store waits for ack
    rf[5] = 16'hCAFE; rf[6] = 16'h0050; dmem[8'h50] = 16'h0000;
    cur_instr = enc(0, 0, 1, 5, 6, 16'h0000); mem_delay = 100;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = mem_req;
    end
    chk("rst_mem.reached_mem", found, 1);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_mem.mem_req", mem_req, 0);
    chk("rst_mem.request_new_pc", request_new_pc, 1);
    chk("rst_mem.pc", pc, 0);
    chk("rst_mem.reg_wen", reg_wen, 0);
    rst = 0; bpc = 0; mem_delay = 1;
    @(negedge clk);
    chk("rst_mem.mem_req_after", mem_req, 0);
    chk("rst_mem.no_write", dmem[8'h50], 16'h0000);

    // halt is absorbing and ignores new_pc_valid
    give_pc(16'h0100);
    do_pass("halt", enc(0, 0, 18, 0, 0, 16'h0000), 1, 0, 0, mode);
    new_pc_valid = 1; new_pc = 16'h0200;
    repeat (3) @(negedge clk);
    new_pc_valid = 0;
    chk("halt.halted", halted, 1);
    chk("halt.pc", pc, 16'h0100);
    chk("halt.request_new_pc", request_new_pc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
